dmi_access_fsm: RTL and testbench

DMI_ACCESS_FSM -- requirements
Module: dmi_access_fsm

---
 rtl/dm_pkg.sv | 31 +++
 rtl/dmi_access_fsm.sv | 128 ++++++++++++
 tb/tb_dmi_access_fsm.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Debug-module transport types shared by the DMI access logic: scan operations,
// request/response bundles and the sticky DMI error codes.
package dm_pkg;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2,
        DTM_PASS  = 2'h3
    } dtm_op_t;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;

    typedef enum logic [1:0] {
        DMINoError  = 2'h0,
        DMIOpFailed = 2'h2,
        DMIBusy     = 2'h3
    } dmi_error_t;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_t     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_access_fsm.sv
// Turns JTAG DMI scan updates into debug-module request/response handshakes and
// keeps the sticky error plus the address/data reloaded into the scan register.
module dmi_access_fsm
    import dm_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        update_i,
    input  logic        capture_i,
    input  logic [6:0]  upd_addr_i,
    input  dtm_op_t     upd_op_i,
    input  logic [31:0] upd_data_i,
    input  logic        dmireset_i,
    output dmi_req_t    dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  dmi_resp_t   dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    output logic [6:0]  cap_addr_o,
    output logic [1:0]  cap_op_o,
    output logic [31:0] cap_data_o
);

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitRead,
        Write,
        WaitWrite
    } state_e;

    state_e      state_q, state_d;
    dmi_error_t  error_q, error_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        in_wait;
    logic        busy_event;
    logic        fail_event;

    assign in_wait    = (state_q == WaitRead) || (state_q == WaitWrite);
    assign busy_event = (state_q != Idle) && (update_i || capture_i);
    assign fail_event = in_wait && dmi_resp_valid_i && (dmi_resp_i.resp != DTM_SUCCESS);

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        dmi_req_o.addr   = addr_q;
        dmi_req_o.op     = DTM_NOP;
        dmi_req_o.data   = data_q;

        case (state_q)
            Idle: begin
                // A pending error locks out new operations until dmireset.
                if (update_i && (error_q == DMINoError)) begin
                    case (upd_op_i)
                        DTM_READ: begin
                            state_d = Read;
                            addr_d  = upd_addr_i;
                            data_d  = upd_data_i;
                        end
                        DTM_WRITE: begin
                            state_d = Write;
                            addr_d  = upd_addr_i;
                            data_d  = upd_data_i;
                        end
                        default: ;
                    endcase
                end
            end
            Read: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_o.op    = DTM_READ;
                if (dmi_req_ready_i) state_d = WaitRead;
            end
            Write: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_o.op    = DTM_WRITE;
                if (dmi_req_ready_i) state_d = WaitWrite;
            end
            WaitRead: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    data_d  = dmi_resp_i.data;
                    state_d = Idle;
                end
            end
            WaitWrite: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    // dmireset beats any simultaneous set; otherwise the first error sticks.
    always_comb begin
        error_d = error_q;
        if (dmireset_i) begin
            error_d = DMINoError;
        end else if (error_q == DMINoError) begin
            if (busy_event)      error_d = DMIBusy;
            else if (fail_event) error_d = DMIOpFailed;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            error_q <= DMINoError;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign cap_addr_o = addr_q;
    assign cap_data_o = data_q;
    assign cap_op_o   = error_q;

endmodule

// File: tb/tb_dmi_access_fsm.sv
// Directed bench for dmi_access_fsm: expected requests go into a queue that a
// negedge monitor drains on every presented request; capture values are checked inline.
module tb_dmi_access_fsm;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update = 1'b0;
    logic        capture = 1'b0;
    logic [6:0]  upd_addr = '0;
    dtm_op_t     upd_op = DTM_NOP;
    logic [31:0] upd_data = '0;
    logic        dmireset = 1'b0;
    dmi_req_t    dmi_req;
    logic        req_valid;
    logic        req_ready = 1'b1;
    dmi_resp_t   dmi_resp = '0;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [6:0]  cap_addr;
    logic [1:0]  cap_op;
    logic [31:0] cap_data;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cycles = 0;
    dmi_req_t exp_q[$];

    always #5 clk = ~clk;

    dmi_access_fsm dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .update_i        (update),
        .capture_i       (capture),
        .upd_addr_i      (upd_addr),
        .upd_op_i        (upd_op),
        .upd_data_i      (upd_data),
        .dmireset_i      (dmireset),
        .dmi_req_o       (dmi_req),
        .dmi_req_valid_o (req_valid),
        .dmi_req_ready_i (req_ready),
        .dmi_resp_i      (dmi_resp),
        .dmi_resp_valid_i(resp_valid),
        .dmi_resp_ready_o(resp_ready),
        .cap_addr_o      (cap_addr),
        .cap_op_o        (cap_op),
        .cap_data_o      (cap_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every cycle a request is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && req_valid) begin
            valid_cycles++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_req: got 0x%0h expected no request", dmi_req);
            end else begin
                check("req_fields", 64'(dmi_req), 64'(exp_q[0]));
                if (req_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic pulse_update(input logic [6:0] a, input dtm_op_t op, input logic [31:0] d);
        @(posedge clk); #1;
        update = 1'b1; upd_addr = a; upd_op = op; upd_data = d;
        @(posedge clk); #1;
        update = 1'b0; upd_op = DTM_NOP;
    endtask

    task automatic pulse_ctl(input logic cap, input logic rst_err);
        @(posedge clk); #1;
        capture = cap; dmireset = rst_err;
        @(posedge clk); #1;
        capture = 1'b0; dmireset = 1'b0;
    endtask

    task automatic wait_resp_ready(input string name);
        int n = 0;
        while (!resp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!resp_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got resp_ready=0 expected 1 within 50 cycles", name);
        end
    endtask

    task automatic send_resp(input logic [31:0] d, input logic [1:0] r);
        @(posedge clk); #1;
        resp_valid = 1'b1; dmi_resp.data = d; dmi_resp.resp = r;
        @(posedge clk); #1;
        resp_valid = 1'b0; dmi_resp = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(req_valid), 64'd0);
        check("rst_resp_ready", 64'(resp_ready), 64'd0);
        check("rst_cap_all", {cap_addr, cap_op, cap_data}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Read, ready immediately
        exp_q.push_back('{addr: 7'h11, op: DTM_READ, data: 32'hDEAD_BEEF});
        pulse_update(7'h11, DTM_READ, 32'hDEAD_BEEF);
        wait_resp_ready("rd1");
        send_resp(32'h0040_0C82, DTM_SUCCESS);
        check("rd1_cap_data", 64'(cap_data), 64'h0040_0C82);
        check("rd1_cap_addr", 64'(cap_addr), 64'h11);
        check("rd1_cap_op", 64'(cap_op), 64'd0);
        check("rd1_idle", 64'(resp_ready | req_valid), 64'd0);

        // Write with ready held low for five cycles
        req_ready = 1'b0;
        valid_cycles = 0;
        exp_q.push_back('{addr: 7'h10, op: DTM_WRITE, data: 32'h8000_0001});
        pulse_update(7'h10, DTM_WRITE, 32'h8000_0001);
        repeat (5) @(posedge clk);
        #1 req_ready = 1'b1;
        wait_resp_ready("wr1");
        check("wr1_valid_cycles", 64'(valid_cycles), 64'd6);
        send_resp(32'hFFFF_FFFF, DTM_SUCCESS);
        check("wr1_cap_data", 64'(cap_data), 64'h8000_0001);
        check("wr1_cap_op", 64'(cap_op), 64'd0);

        // Busy: update while waiting for a read response
        exp_q.push_back('{addr: 7'h05, op: DTM_READ, data: 32'h0});
        pulse_update(7'h05, DTM_READ, 32'h0);
        wait_resp_ready("rd2");
        pulse_update(7'h7F, DTM_READ, 32'h1111_1111);
        check("busy_resp_ready", 64'(resp_ready), 64'd1);
        send_resp(32'h0000_1234, DTM_SUCCESS);
        check("busy_cap_op", 64'(cap_op), 64'd3);
        check("busy_cap_data", 64'(cap_data), 64'h1234);
        check("busy_cap_addr", 64'(cap_addr), 64'h05);
        pulse_update(7'h06, DTM_READ, 32'h0);
        repeat (4) @(negedge clk);
        check("locked_cap_addr", 64'(cap_addr), 64'h05);
        check("locked_valid", 64'(req_valid), 64'd0);
        pulse_ctl(1'b0, 1'b1);
        check("dmireset_cap_op", 64'(cap_op), 64'd0);
        exp_q.push_back('{addr: 7'h06, op: DTM_READ, data: 32'h0});
        pulse_update(7'h06, DTM_READ, 32'h0);
        wait_resp_ready("rd3");
        send_resp(32'h0000_CAFE, DTM_SUCCESS);
        check("rd3_cap_data", 64'(cap_data), 64'hCAFE);

        // Failed write response, error stays through later events
        exp_q.push_back('{addr: 7'h20, op: DTM_WRITE, data: 32'h55});
        pulse_update(7'h20, DTM_WRITE, 32'h55);
        wait_resp_ready("wr2");
        send_resp(32'h0, 2'h2);
        check("fail_cap_op", 64'(cap_op), 64'd2);
        pulse_ctl(1'b1, 1'b0);
        pulse_update(7'h21, DTM_READ, 32'h0);
        repeat (2) @(negedge clk);
        check("fail_sticky", 64'(cap_op), 64'd2);
        check("fail_no_latch", 64'(cap_addr), 64'h20);
        pulse_ctl(1'b0, 1'b1);
        check("fail_cleared", 64'(cap_op), 64'd0);

        // dmireset coincident with a busy capture in WaitWrite
        exp_q.push_back('{addr: 7'h30, op: DTM_WRITE, data: 32'h7});
        pulse_update(7'h30, DTM_WRITE, 32'h7);
        wait_resp_ready("wr3");
        pulse_ctl(1'b1, 1'b1);
        check("reset_wins_cap_op", 64'(cap_op), 64'd0);
        send_resp(32'h0, DTM_SUCCESS);
        check("wr3_cap_op", 64'(cap_op), 64'd0);

        // Asynchronous reset during a stalled write
        req_ready = 1'b0;
        exp_q.push_back('{addr: 7'h3F, op: DTM_WRITE, data: 32'hA5A5_0000});
        pulse_update(7'h3F, DTM_WRITE, 32'hA5A5_0000);
        @(negedge clk);
        check("pre_rst_valid", 64'(req_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(req_valid), 64'd0);
        check("async_rst_caps", {cap_addr, cap_op, cap_data}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 64'({req_valid, resp_ready}), 64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
